// File: rtl/sextium_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sextium_io_pkg
// Description : Shared types and defaults for the Sextium CPU I/O port:
//               access FSM state encoding and default word/FIFO sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package sextium_io_pkg;

   localparam int IO_WIDTH_DEF = 16;
   localparam int IO_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IO_IDLE    = 2'd0,
      IO_RD_WAIT = 2'd1,
      IO_WR_WAIT = 2'd2,
      IO_ACK     = 2'd3
   } io_state_t;

endpackage
`default_nettype wire

// File: rtl/sextium_io_if.sv
`default_nettype none
// ============================================================================
// Module      : sextium_io_if
// Description : CPU strobe bus plus external RX/TX valid/ready streams of the
//               Sextium I/O port. master = CPU/environment, slave = port.
// Revision    : 1.0 - initial release
// ============================================================================
interface sextium_io_if #(
   parameter int WIDTH = sextium_io_pkg::IO_WIDTH_DEF
);
   logic             io_read;
   logic             io_write;
   logic [WIDTH-1:0] io_wdata;
   logic [WIDTH-1:0] io_rdata;
   logic             io_done;
   logic             io_err;
   logic             rx_valid;
   logic [WIDTH-1:0] rx_data;
   logic             rx_ready;
   logic             tx_valid;
   logic [WIDTH-1:0] tx_data;
   logic             tx_ready;

   modport master (
      output io_read, io_write, io_wdata, rx_valid, rx_data, tx_ready,
      input  io_rdata, io_done, io_err, rx_ready, tx_valid, tx_data
   );

   modport slave (
      input  io_read, io_write, io_wdata, rx_valid, rx_data, tx_ready,
      output io_rdata, io_done, io_err, rx_ready, tx_valid, tx_data
   );
endinterface
`default_nettype wire

// File: rtl/sextium_io_port_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Synchronous FIFO, power-of-two depth, registered head (no
//               bypass). Push when full / pop when empty are ignored.
//               Only pointers and count are reset, storage is not.
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  wire logic                     clock,
   input  wire logic                     reset,
   input  wire logic                     i_push,
   input  wire logic [WIDTH-1:0]         i_wdata,
   input  wire logic                     i_pop,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(DEPTH):0]        o_count,
   output logic [WIDTH-1:0]              o_head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Storage write; data is deliberately left unreset.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   // Pointers wrap naturally; count moves by the net push/pop change.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/sextium_io_port.sv
`default_nettype none
// ============================================================================
// Module      : sextium_io_port
// Description : Responder for the Sextium CPU io_read/io_write strobes. CPU
//               writes go to a TX FIFO drained by an external sink; external
//               words land in an RX FIFO for CPU reads. Accesses stretch
//               (4-phase req/done) while the FIFO is empty/full.
//               Optional macro IO_LOOPBACK_EN adds lb_en: TX head -> RX.
// Revision    : 1.0 - initial release
// ============================================================================
module sextium_io_port
   import sextium_io_pkg::*;
#(
   parameter int WIDTH = IO_WIDTH_DEF,
   parameter int DEPTH = IO_DEPTH_DEF
) (
   input  wire logic clock,
   input  wire logic reset,
`ifdef IO_LOOPBACK_EN
   input  wire logic lb_en,
`endif
   sextium_io_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   io_state_t        r_state;
   io_state_t        w_state_nxt;
   logic             r_done;
   logic             r_err;
   logic [WIDTH-1:0] r_rdata;

   logic             w_lb;
   logic             w_rx_push;
   logic             w_rx_pop;
   logic [WIDTH-1:0] w_rx_din;
   logic [WIDTH-1:0] w_rx_head;
   logic             w_rx_full;
   logic             w_rx_empty;
   logic [CW-1:0]    w_rx_cnt;
   logic             w_tx_push;
   logic             w_tx_pop;
   logic [WIDTH-1:0] w_tx_head;
   logic             w_tx_full;
   logic             w_tx_empty;
   logic [CW-1:0]    w_tx_cnt;
   logic             w_err_set;

`ifdef IO_LOOPBACK_EN
   assign w_lb = lb_en;
`else
   assign w_lb = 1'b0;
`endif

   // In loopback the TX head moves straight into RX; the external paths idle.
   assign w_rx_push = w_lb ? (~w_tx_empty & ~w_rx_full) : (bus.rx_valid & ~w_rx_full);
   assign w_rx_din  = w_lb ? w_tx_head : bus.rx_data;
   assign w_tx_pop  = w_lb ? (~w_tx_empty & ~w_rx_full) : (~w_tx_empty & bus.tx_ready);

   assign bus.rx_ready = ~w_lb & ~w_rx_full;
   assign bus.tx_valid = ~w_lb & ~w_tx_empty;
   assign bus.tx_data  = w_tx_head;
   assign bus.io_done  = r_done;
   assign bus.io_err   = r_err;
   assign bus.io_rdata = r_rdata;

   io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_rx_push),
      .i_wdata (w_rx_din),
      .i_pop   (w_rx_pop),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_rx_cnt),
      .o_head  (w_rx_head)
   );

   io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_tx_push),
      .i_wdata (bus.io_wdata),
      .i_pop   (w_tx_pop),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_cnt),
      .o_head  (w_tx_head)
   );

   // Access FSM: accept, wait for data/space, then hold done until release.
   always_comb begin
      w_state_nxt = r_state;
      w_rx_pop    = 1'b0;
      w_tx_push   = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         IO_IDLE: begin
            if (bus.io_read) begin
               w_err_set = bus.io_write;
               if (w_rx_cnt != '0) begin
                  w_rx_pop    = 1'b1;
                  w_state_nxt = IO_ACK;
               end else begin
                  w_state_nxt = IO_RD_WAIT;
               end
            end else if (bus.io_write) begin
               if (w_tx_cnt < CW'(DEPTH)) begin
                  w_tx_push   = 1'b1;
                  w_state_nxt = IO_ACK;
               end else begin
                  w_state_nxt = IO_WR_WAIT;
               end
            end
         end
         IO_RD_WAIT: begin
            if (!bus.io_read) begin
               w_state_nxt = IO_IDLE;
            end else if (w_rx_cnt != '0) begin
               w_rx_pop    = 1'b1;
               w_state_nxt = IO_ACK;
            end
         end
         IO_WR_WAIT: begin
            if (!bus.io_write) begin
               w_state_nxt = IO_IDLE;
            end else if (w_tx_cnt < CW'(DEPTH)) begin
               w_tx_push   = 1'b1;
               w_state_nxt = IO_ACK;
            end
         end
         IO_ACK: begin
            if (!bus.io_read && !bus.io_write) w_state_nxt = IO_IDLE;
         end
         default: w_state_nxt = IO_IDLE;
      endcase
   end

   // State, registered done/rdata and the sticky conflict flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IO_IDLE;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_state_nxt == IO_ACK);
         r_err   <= r_err | w_err_set;
         if (w_rx_pop) r_rdata <= w_rx_head;
      end
   end
endmodule
`default_nettype wire

// File: doc/sextium_io_port.md
Name: sextium_io_port

Overview:
- Responder end of the CPU I/O strobe interface: services the controller's io_read/io_write requests for SYSCALL-style word I/O.
- Buffers CPU output words in a TX FIFO, drained by an external valid/ready sink (console/UART bridge).
- Buffers incoming words from an external valid/ready source in an RX FIFO for CPU reads.
- Stretches the CPU access with a 4-phase req/done handshake while a FIFO is empty/full.

Parameters:
WIDTH, 16, data word width (Sextium word)
DEPTH, 4, entries per FIFO; power of two, >=2

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
io_read  input  1  CPU read request, level, held until io_done seen
io_write  input  1  CPU write request, level, held until io_done seen
io_wdata  input  WIDTH  word to output; sampled when the write is accepted
io_rdata  output  WIDTH  word read; valid while io_done=1 after a read
io_done  output  1  access complete; held high until both requests low
io_err  output  1  sticky: io_read and io_write seen high together in IDLE
rx_valid  input  1  external source has a word
rx_data  input  WIDTH  external word
rx_ready  output  1  = RX FIFO not full
tx_valid  output  1  = TX FIFO not empty
tx_data  output  WIDTH  TX FIFO head word
tx_ready  input  1  external sink accepts tx_data

Behaviour:
- Reset (async, reset=0): state IDLE; io_done=0, io_rdata=0, io_err=0; both FIFOs empty (rx_ready=1, tx_valid=0). A reset mid-access abandons it: no push/pop completes, the FIFO keeps nothing.
- FSM states: IDLE, RD_WAIT, WR_WAIT, ACK.
- IDLE, io_read=1: if RX nonempty, pop into io_rdata and go to ACK. Otherwise go to RD_WAIT.
- IDLE, io_write=1: if TX not full, push io_wdata and go to ACK. Otherwise go to WR_WAIT.
- IDLE, both requests high: set io_err and treat the access as a read.
- RD_WAIT: on the first cycle RX count>0, pop into io_rdata and go to ACK.
- WR_WAIT: on the first cycle TX count<DEPTH, push io_wdata and go to ACK.
- ACK: io_done=1 (registered, so done rises 1 cycle after acceptance; best-case latency req->done = 1 clock). Stay in ACK until io_read=0 and io_write=0, then io_done=0 and go to IDLE. No new access can start in the same cycle; this prevents double pops/pushes from held strobes.
- Request dropped in RD_WAIT/WR_WAIT before completion: return to IDLE with no FIFO side effect.
- io_rdata holds its last value outside ACK.
- External side: push RX when rx_valid & rx_ready. Pop TX when tx_valid & tx_ready.
- Same-cycle external push and CPU pop on the same FIFO are legal. Count updates by net change (+1-1=0).
- No bypass: a word pushed into an empty RX is poppable the next cycle at the earliest.
- Full-TX CPU push and external pop in the same cycle: the push is not taken that cycle; it completes next cycle via WR_WAIT.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- FIFO data is not reset; only pointers and counts are.

Optional Feature:
IO_LOOPBACK_EN
- Defined: adds input lb_en (1 bit).
  - When lb_en=1, the TX FIFO head feeds the RX FIFO push whenever TX is nonempty and RX is not full.
  - External rx_valid is ignored and rx_ready=0.
  - External tx_valid=0 and tx_ready is ignored.
  - When lb_en=0, behaviour is identical to the non-loopback build.
- Undefined: no lb_en port; external paths only.

Decomposition:
- Package sextium_io_pkg holds:
  - FSM state encodings IO_IDLE=0, IO_RD_WAIT=1, IO_WR_WAIT=2, IO_ACK=3 (2 bits)
  - default WIDTH/DEPTH constants
- One natural sub-module, io_fifo (WIDTH, DEPTH): push/pop/full/empty/count/head, async active-low reset. It is instantiated twice, as RX and TX.
- The top holds the FSM, the io_err flag and the loopback muxing.

Test Plan:
1. Read, RX preloaded: rx_valid pushes 0x1234. Raise io_read. Expect io_done=1 one cycle later with io_rdata=0x1234. Drop io_read; expect io_done=0 the next cycle and RX empty.
2. Read on empty RX: io_read high for 5 cycles with no data, so io_done stays 0. Then push 0xBEEF. Expect io_done 1 cycle after the push with io_rdata=0xBEEF and only one pop.
3. Write fill: 4 writes of 0x0001..0x0004 with tx_ready=0 all complete. A 5th write of 0x0005 stalls in WR_WAIT. Pulse tx_ready for one cycle: tx_data=0x0001 leaves, then the 5th write completes and the FIFO order is 2,3,4,5.
4. Held strobe: io_write held high for 10 cycles after io_done. Expect exactly one push and io_done held high for the whole period.
5. Conflict and reset: io_read and io_write high together in IDLE give io_err=1 and a read is serviced. Assert reset mid-RD_WAIT: io_err=0, io_done=0, FIFOs empty, rx_ready=1.
6. (IO_LOOPBACK_EN) lb_en=1: write 0x00AA, then read. Expect io_rdata=0x00AA and tx_valid=0 throughout.
